axi_rd_initiator: RTL and testbench
===================================

AXI_RD_INITIATOR -- requirements
Module: axi_rd_initiator

Interface
REQ-001 Single clock clk; reset is synchronous and active-high, named reset.
REQ-002 Parameter BURST_LEN, default 8'h0F: ARLEN driven on every request (beats = BURST_LEN+1).
REQ-003 Parameter MAX_OUTST, default 8: maximum accepted-but-uncompleted bursts, range 1..14.
REQ-004 Parameter NUM_BURSTS, default 16'd0: bursts to issue per run; 0 = unlimited.
REQ-005 Parameter BASE_ADDR, default 32'h0: first ARADDR of a run.
REQ-006 clk  input  1  clock.
REQ-007 reset  input  1  sync active-high reset.
REQ-008 en  input  1  run enable.
REQ-009 ARREADY  input  1  address accepted.
REQ-010 ARADDR  output  32  burst address.
REQ-011 ARID  output  4  burst ID.
REQ-012 ARLEN  output  8  equals BURST_LEN.
REQ-013 ARVALID  output  1  request valid.
REQ-014 RREADY  output  1  data accept.
REQ-015 RID / RDATA / RRESP / RLAST / RVALID  input  4/512/2/1/1  read data channel.
REQ-016 busy  output  1  state is RUN or DRAIN.
REQ-017 done  output  1  state is DONE.
REQ-018 err  output  1  sticky: any check failure.
REQ-019 err_cnt  output  16  count of failing beats, saturating at 16'hFFFF.

Function
REQ-020 FSM states IDLE, RUN, DRAIN, DONE. IDLE->RUN when en=1. RUN->DRAIN when en=0, or when NUM_BURSTS!=0 and the issued count reaches NUM_BURSTS. DRAIN->DONE when outstanding==0. DONE->IDLE when en=0.
REQ-021 ARVALID is asserted in RUN only while outstanding < MAX_OUTST. Once asserted, ARVALID and ARADDR/ARID stay stable until ARREADY, even if the FSM leaves RUN.
REQ-022 Per accepted AR (ARVALID&&ARREADY): ARID += 1 (wraps mod 16), ARADDR += (BURST_LEN+1)*64 (wraps mod 2^32), issued count += 1.
REQ-023 outstanding +1 on AR accept; -1 on RVALID&&RREADY&&RLAST; unchanged when both occur in the same cycle.
REQ-024 RREADY=1 in RUN and DRAIN, 0 otherwise.
REQ-025 Expected-pattern state: exp_cnt[15:0], exp_stream[7:0], exp_iter[7:0]=0, exp_rid[3:0].
REQ-026 Expected RDATA word k (32-bit, k=0..15, k=0 at LSB) = {exp_stream, exp_iter, exp_cnt+k}.
REQ-027 Each accepted beat: exp_cnt += 16'h10. If RLAST && exp_cnt==16'hE0F0: exp_cnt <= 0, and exp_stream increments, wrapping 11 -> 0.
REQ-028 A beat fails on any of: RDATA mismatch, RRESP != 2'b00, RID != exp_rid, or RLAST != (beat index within burst == BURST_LEN). A failure sets err and increments err_cnt (saturating).
REQ-029 exp_rid += 1 on each accepted RLAST beat. RLAST received early or late still closes the burst for accounting.
REQ-030 RVALID with zero outstanding is a failure; the beat is consumed and outstanding stays 0 (no underflow).
REQ-031 Each IDLE->RUN transition restores ARADDR=BASE_ADDR and issued=0. err, err_cnt and the pattern state persist across runs.

Reset
REQ-032 On reset: state IDLE, ARVALID=0, RREADY=0, ARADDR=BASE_ADDR, ARID=0, outstanding=0, issued=0, exp_cnt=0, exp_stream=0, exp_rid=0, err=0, err_cnt=0, busy=0, done=0.
REQ-033 Reset asserted mid-burst aborts immediately to the reset values; no drain.

Structure
REQ-034 Shared package holds the FSM state encoding, the 16'hE0F0 stream-end constant, the stream wrap value 11, and the 64-byte beat size.
REQ-035 One sub-module, axi_rd_pattern_chk, contains the expected-pattern state and the beat comparator (REQ-025..030).

Verification
REQ-036 Against axi_target_bfm, en=1, NUM_BURSTS=32, BURST_LEN=15 -> done asserts; err=0; 512 beats; final ARADDR=BASE_ADDR+32768.
REQ-037 ARREADY held low for 20 cycles with ARVALID high -> ARADDR and ARID stable throughout; single accept.
REQ-038 Responder never returns RLAST, MAX_OUTST=4 -> exactly 4 AR accepts, then ARVALID=0.
REQ-039 Bit 0 of word 3 flipped in one beat -> err=1, err_cnt=1; later clean beats do not increment err_cnt.
REQ-040 Run through exp_cnt=16'hE0F0 on RLAST, 12 times -> exp_stream steps 0..11 then returns to 0, err=0.
REQ-041 AR accept and RLAST in the same cycle, and reset asserted mid-burst -> outstanding unchanged for the first case; all outputs return to reset values on the next cycle for the second.

Source files
------------

// File: rtl/axi_rd_initiator_pkg.sv
// Shared definitions for the AXI read initiator and its pattern checker.
package axi_rd_initiator_pkg;

  // Run-control FSM encoding; exported on the debug port of the top.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // exp_cnt value which, on a burst-closing beat, ends the current stream.
  localparam logic [15:0] STREAM_END     = 16'hE0F0;
  // Last stream number before exp_stream wraps back to zero.
  localparam logic [7:0]  STREAM_WRAP    = 8'd11;
  // Bytes carried by one 512-bit data beat.
  localparam logic [31:0] BEAT_BYTES     = 32'd64;
  // exp_cnt advance per accepted beat.
  localparam logic [15:0] CNT_STEP       = 16'h0010;
  // 32-bit words per data beat.
  localparam int          WORDS_PER_BEAT = 16;
  // Iteration byte of the expected pattern; always zero in this design.
  localparam logic [7:0]  EXP_ITER       = 8'h00;

endpackage

// File: rtl/axi_rd_pattern_chk.sv
// Expected-pattern tracker and per-beat comparator for the read data channel.
module axi_rd_pattern_chk
  import axi_rd_initiator_pkg::*;
#(
  parameter logic [7:0] BURST_LEN = 8'h0F
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         beat,        // RVALID && RREADY this cycle
  input  logic         burst_open,  // at least one burst is outstanding
  input  logic [3:0]   rid,
  input  logic [511:0] rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  output logic         err,
  output logic [15:0]  err_cnt
);

  logic [15:0]  exp_cnt;
  logic [7:0]   exp_stream;
  logic [3:0]   exp_rid;
  logic [7:0]   beat_idx;
  logic [511:0] exp_data;
  logic         bad;

  // Build the expected beat and decide whether the presented beat fails.
  always_comb begin
    exp_data = '0;
    for (int k = 0; k < WORDS_PER_BEAT; k++) begin
      exp_data[k*32 +: 32] = {exp_stream, EXP_ITER, exp_cnt + 16'(k)};
    end
    bad = !burst_open || (rdata != exp_data) || (rresp != 2'b00) ||
          (rid != exp_rid) || (rlast != (beat_idx == BURST_LEN));
  end

  // Count failures and advance the pattern on beats that belong to a burst.
  // A beat arriving with nothing outstanding is a failure only: it is not
  // part of any burst, so the expected pattern does not move.
  always_ff @(posedge clk) begin
    if (reset) begin
      exp_cnt    <= '0;
      exp_stream <= '0;
      exp_rid    <= '0;
      beat_idx   <= '0;
      err        <= 1'b0;
      err_cnt    <= '0;
    end else if (beat) begin
      if (bad) begin
        err <= 1'b1;
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      end
      if (burst_open) begin
        if (rlast) begin
          beat_idx <= '0;
          exp_rid  <= exp_rid + 4'd1;
        end else if (beat_idx != 8'hFF) begin
          beat_idx <= beat_idx + 8'd1;
        end
        if (rlast && (exp_cnt == STREAM_END)) begin
          exp_cnt    <= '0;
          exp_stream <= (exp_stream == STREAM_WRAP) ? 8'd0 : exp_stream + 8'd1;
        end else begin
          exp_cnt <= exp_cnt + CNT_STEP;
        end
      end
    end
  end

endmodule

// File: rtl/axi_rd_initiator.sv
// AXI read initiator: issues fixed-length bursts at increasing addresses and
// checks the returned data against a deterministic pattern.
//
// Handshakes: a transfer happens on a rising edge where VALID and READY are
// both high. Once ARVALID rises, ARVALID/ARADDR/ARID hold until ARREADY, even
// if the run stops meanwhile. RREADY depends only on the FSM state, never on
// RVALID.
module axi_rd_initiator
  import axi_rd_initiator_pkg::*;
#(
  parameter logic [7:0]  BURST_LEN  = 8'h0F,
  parameter int          MAX_OUTST  = 8,
  parameter logic [15:0] NUM_BURSTS = 16'd0,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         ARREADY,
  output logic [31:0]  ARADDR,
  output logic [3:0]   ARID,
  output logic [7:0]   ARLEN,
  output logic         ARVALID,
  output logic         RREADY,
  input  logic [3:0]   RID,
  input  logic [511:0] RDATA,
  input  logic [1:0]   RRESP,
  input  logic         RLAST,
  input  logic         RVALID,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [15:0]  err_cnt,
  output state_t       state_dbg,
  output logic [3:0]   outstanding_dbg
);

  localparam logic [3:0]  MAX_O     = 4'(MAX_OUTST);
  localparam logic [31:0] ADDR_STEP = (32'(BURST_LEN) + 32'd1) * BEAT_BYTES;

  state_t      state;
  logic [3:0]  outstanding;
  logic [3:0]  outst_nxt;
  logic [15:0] issued;
  logic [15:0] issued_nxt;
  logic        ar_fire;
  logic        r_fire;
  logic        r_close;
  logic        stay_run;

  assign ARLEN           = BURST_LEN;
  assign state_dbg       = state;
  assign outstanding_dbg = outstanding;

  // Handshake decode and next values of the burst counters.
  always_comb begin
    ar_fire   = ARVALID && ARREADY;
    r_fire    = RVALID && RREADY;
    r_close   = r_fire && RLAST && (outstanding != 4'd0);
    outst_nxt = outstanding;
    if (ar_fire && !r_close)      outst_nxt = outstanding + 4'd1;
    else if (!ar_fire && r_close) outst_nxt = outstanding - 4'd1;
    issued_nxt = issued + {15'd0, ar_fire};
    stay_run   = en && !((NUM_BURSTS != 16'd0) && (issued_nxt >= NUM_BURSTS));
  end

  // Run-control FSM with registered request and status outputs. DRAIN also
  // waits for a still-pending address: once offered it will be accepted and
  // its data must be collected before the run can report done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      RREADY      <= 1'b0;
      ARVALID     <= 1'b0;
      ARADDR      <= BASE_ADDR;
      ARID        <= '0;
      issued      <= '0;
      outstanding <= '0;
    end else begin
      outstanding <= outst_nxt;
      issued      <= issued_nxt;
      if (ar_fire) begin
        ARADDR <= ARADDR + ADDR_STEP;
        ARID   <= ARID + 4'd1;
      end
      if (ARVALID && !ARREADY) ARVALID <= 1'b1;
      else ARVALID <= (state == ST_RUN) && stay_run && (outst_nxt < MAX_O);
      case (state)
        ST_IDLE: if (en) begin
          state  <= ST_RUN;
          busy   <= 1'b1;
          RREADY <= 1'b1;
          ARADDR <= BASE_ADDR;
          issued <= '0;
        end
        ST_RUN: if (!stay_run) state <= ST_DRAIN;
        ST_DRAIN: if ((outstanding == 4'd0) && !ARVALID) begin
          state  <= ST_DONE;
          busy   <= 1'b0;
          done   <= 1'b1;
          RREADY <= 1'b0;
        end
        ST_DONE: if (!en) begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axi_rd_pattern_chk #(.BURST_LEN(BURST_LEN)) u_chk (
    .clk        (clk),
    .reset      (reset),
    .beat       (r_fire),
    .burst_open (outstanding != 4'd0),
    .rid        (RID),
    .rdata      (RDATA),
    .rresp      (RRESP),
    .rlast      (RLAST),
    .err        (err),
    .err_cnt    (err_cnt)
  );

endmodule

// File: tb/tb_axi_rd_initiator.sv
// Bench for axi_rd_initiator: a target model answers read bursts with the
// expected data pattern; scenario tasks check run control and checking.
module tb_axi_rd_initiator;
  import axi_rd_initiator_pkg::*;

  localparam logic [7:0]  BL        = 8'h0F;
  localparam int          MO        = 4;
  localparam logic [15:0] NB        = 16'd32;
  localparam logic [31:0] BASE      = 32'hFFFF_C000;
  localparam logic [31:0] ADDR_STEP = 32'd1024;
  localparam int AR_MANUAL = 0, AR_ALWAYS = 1, AR_RANDOM = 2;
  localparam int R_OFF = 0, R_NORMAL = 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, ARREADY = 1'b0;
  logic [31:0] ARADDR; logic [3:0] ARID; logic [7:0] ARLEN; logic ARVALID, RREADY;
  logic [3:0] RID = '0; logic [511:0] RDATA = '0; logic [1:0] RRESP = '0;
  logic RLAST = 1'b0, RVALID = 1'b0;
  logic busy, done, err; logic [15:0] err_cnt; state_t state_dbg; logic [3:0] outstanding_dbg;

  always #5 clk = ~clk;

  axi_rd_initiator #(.BURST_LEN(BL), .MAX_OUTST(MO), .NUM_BURSTS(NB), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .en(en), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID),
    .ARLEN(ARLEN), .ARVALID(ARVALID), .RREADY(RREADY), .RID(RID), .RDATA(RDATA),
    .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .busy(busy), .done(done), .err(err),
    .err_cnt(err_cnt), .state_dbg(state_dbg), .outstanding_dbg(outstanding_dbg));

  int checks = 0, failures = 0;

  // ---------------- target model / scoreboard state ----------------
  int ar_mode = AR_MANUAL, r_mode = R_NORMAL;
  bit r_gaps = 1'b0, corrupt_req = 1'b0, stray_req = 1'b0, cur_stray = 1'b0;
  logic [3:0] id_q[$];            // IDs of accepted bursts awaiting data
  int beat_i = 0;                 // beat number within the burst being returned
  logic [15:0] m_cnt = '0;        // pattern counter of the next beat
  logic [7:0] m_stream = '0;      // pattern stream of the next beat
  int stream_steps = 0, ar_count = 0, ar_bad = 0, beat_count = 0, stray_done = 0;
  logic [31:0] exp_addr = BASE;   // address the next accepted request must carry
  logic [3:0] exp_id = '0;        // ID the next accepted request must carry

  function automatic logic [511:0] pattern(input logic [15:0] c, input logic [7:0] s);
    logic [511:0] d;
    for (int k = 0; k < 16; k++) d[k*32 +: 32] = {s, 8'h00, c + 16'(k)};
    return d;
  endfunction

  // Target: samples handshakes just before each edge, updates after the edge.
  initial begin : target
    bit ar_f, r_f, rst_s, last_s;
    logic [31:0] a_s; logic [3:0] id_s;
    forever begin
      @(negedge clk); #3;
      rst_s = reset; ar_f = ARVALID && ARREADY; a_s = ARADDR; id_s = ARID;
      r_f = RVALID && RREADY; last_s = RLAST;
      @(posedge clk); #1;
      if (rst_s) begin
        id_q.delete(); beat_i = 0; m_cnt = '0; m_stream = '0; exp_id = '0;
        RVALID = 1'b0; RLAST = 1'b0; cur_stray = 1'b0;
      end else begin
        if (ar_f) begin
          if (a_s !== exp_addr || id_s !== exp_id) ar_bad++;
          exp_addr = exp_addr + ADDR_STEP; exp_id = exp_id + 4'd1; ar_count++;
          id_q.push_back(id_s);
        end
        if (r_f) begin
          RVALID = 1'b0;
          if (cur_stray) begin
            cur_stray = 1'b0; stray_done++;
          end else begin
            beat_count++;
            if (last_s) begin
              void'(id_q.pop_front()); beat_i = 0;
              if (m_cnt == 16'hE0F0) begin
                m_cnt = '0; m_stream = (m_stream == 8'd11) ? 8'd0 : m_stream + 8'd1; stream_steps++;
              end else m_cnt = m_cnt + 16'h10;
            end else begin
              beat_i++; m_cnt = m_cnt + 16'h10;
            end
          end
        end
        if (ar_mode == AR_ALWAYS) ARREADY = 1'b1;
        else if (ar_mode == AR_RANDOM) ARREADY = ($urandom_range(0, 2) != 0);
        if (!RVALID) begin
          if (stray_req && id_q.size() == 0) begin
            stray_req = 1'b0; cur_stray = 1'b1; RVALID = 1'b1; RID = 4'hA;
            RDATA = {16{$urandom()}}; RRESP = 2'b00; RLAST = 1'b1;
          end else if (r_mode == R_NORMAL && id_q.size() > 0 && (!r_gaps || $urandom_range(0, 3) != 0)) begin
            RVALID = 1'b1; RID = id_q[0]; RDATA = pattern(m_cnt, m_stream);
            RRESP = 2'b00; RLAST = (beat_i == int'(BL));
            if (corrupt_req) begin RDATA[96] = ~RDATA[96]; corrupt_req = 1'b0; end
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b1; en = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    ar_count = 0; ar_bad = 0; beat_count = 0; stray_done = 0; stream_steps = 0;
    corrupt_req = 1'b0; stray_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic do_run(input int budget, output bit ok);
    exp_addr = BASE; en = 1'b1;
    wait_done(budget, ok);
    en = 1'b0;
    @(negedge clk); @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; en = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (state_dbg !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state_dbg, ST_IDLE); end
    checks++; if (ARVALID !== 1'b0) begin failures++; $display("FAIL reset_arvalid got=%0b exp=0", ARVALID); end
    checks++; if (RREADY !== 1'b0) begin failures++; $display("FAIL reset_rready got=%0b exp=0", RREADY); end
    checks++; if (ARADDR !== BASE) begin failures++; $display("FAIL reset_araddr got=%h exp=%h", ARADDR, BASE); end
    checks++; if (ARID !== 4'd0) begin failures++; $display("FAIL reset_arid got=%0d exp=0", ARID); end
    checks++; if (ARLEN !== BL) begin failures++; $display("FAIL reset_arlen got=%0d exp=%0d", ARLEN, BL); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_status got=%0b%0b exp=00", busy, done); end
    checks++; if (err !== 1'b0 || err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err got=%0b/%0d exp=0/0", err, err_cnt); end
    checks++; if (outstanding_dbg !== 4'd0) begin failures++; $display("FAIL reset_outst got=%0d exp=0", outstanding_dbg); end
    reset = 1'b0;
  endtask

  task automatic test_full_run();
    bit ok;
    do_reset();
    ar_mode = AR_RANDOM; r_mode = R_NORMAL; r_gaps = 1'b1;
    exp_addr = BASE; en = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (busy !== 1'b1 || state_dbg !== ST_RUN || RREADY !== 1'b1) begin failures++; $display("FAIL run_busy got=%0b/%0d/%0b exp=1/%0d/1", busy, state_dbg, RREADY, ST_RUN); end
    wait_done(6000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL run_done got=timeout exp=done"); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL run_err got=%0b exp=0", err); end
    checks++; if (beat_count != 512) begin failures++; $display("FAIL run_beats got=%0d exp=512", beat_count); end
    checks++; if (ar_count != 32 || ar_bad != 0) begin failures++; $display("FAIL run_ar got=%0d/%0d bad exp=32/0", ar_count, ar_bad); end
    checks++; if (ARADDR !== BASE + 32'd32768) begin failures++; $display("FAIL run_final_addr got=%h exp=%h", ARADDR, BASE + 32'd32768); end
    checks++; if (busy !== 1'b0 || outstanding_dbg !== 4'd0) begin failures++; $display("FAIL run_idle_outst got=%0b/%0d exp=0/0", busy, outstanding_dbg); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (done !== 1'b0 || state_dbg !== ST_IDLE) begin failures++; $display("FAIL run_back_idle got=%0b/%0d exp=0/%0d", done, state_dbg, ST_IDLE); end
  endtask

  task automatic test_ar_stall();
    bit ok, seen;
    logic [31:0] a0; logic [3:0] i0;
    do_reset();
    ar_mode = AR_MANUAL; ARREADY = 1'b0; r_mode = R_NORMAL; r_gaps = 1'b0;
    exp_addr = BASE; en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = ARVALID; end
    checks++; if (!seen) begin failures++; $display("FAIL stall_arvalid got=0 exp=1"); end
    a0 = ARADDR; i0 = ARID;
    checks++; if (a0 !== BASE || i0 !== 4'd0) begin failures++; $display("FAIL stall_first got=%h/%0d exp=%h/0", a0, i0, BASE); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (ARVALID !== 1'b1 || ARADDR !== a0 || ARID !== i0) begin failures++; $display("FAIL stall_hold got=%0b/%h/%0d exp=1/%h/%0d", ARVALID, ARADDR, ARID, a0, i0); end
    end
    ARREADY = 1'b1; @(negedge clk); ARREADY = 1'b0;
    checks++; if (ar_count != 1 || ARADDR !== BASE + ADDR_STEP) begin failures++; $display("FAIL stall_single got=%0d/%h exp=1/%h", ar_count, ARADDR, BASE + ADDR_STEP); end
    en = 1'b0;
    @(negedge clk);
    checks++; if (state_dbg !== ST_DRAIN || ARVALID !== 1'b1 || RREADY !== 1'b1) begin failures++; $display("FAIL stall_drain_hold got=%0d/%0b/%0b exp=%0d/1/1", state_dbg, ARVALID, RREADY, ST_DRAIN); end
    ARREADY = 1'b1; @(negedge clk); ARREADY = 1'b0;
    checks++; if (ar_count != 2 || ARVALID !== 1'b0) begin failures++; $display("FAIL stall_drain_accept got=%0d/%0b exp=2/0", ar_count, ARVALID); end
    wait_done(500, ok);
    checks++; if (!ok || err !== 1'b0 || ar_bad != 0 || beat_count != 32) begin failures++; $display("FAIL stall_finish got=%0b/%0b/%0d/%0d exp=1/0/0/32", ok, err, ar_bad, beat_count); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_same_cycle();
    bit ok, found;
    do_reset();
    ar_mode = AR_MANUAL; ARREADY = 1'b0; r_mode = R_NORMAL; r_gaps = 1'b0;
    exp_addr = BASE; en = 1'b1;
    for (int i = 0; i < 20 && !ARVALID; i++) @(negedge clk);
    ARREADY = 1'b1; @(negedge clk); ARREADY = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (ARVALID && RVALID && RREADY && RLAST) begin
        found = 1'b1;
        checks++; if (outstanding_dbg !== 4'd1) begin failures++; $display("FAIL same_before got=%0d exp=1", outstanding_dbg); end
        ARREADY = 1'b1; @(negedge clk); ARREADY = 1'b0;
        checks++; if (outstanding_dbg !== 4'd1) begin failures++; $display("FAIL same_after got=%0d exp=1", outstanding_dbg); end
        checks++; if (ar_count != 2) begin failures++; $display("FAIL same_accepts got=%0d exp=2", ar_count); end
      end
    end
    checks++; if (!found) begin failures++; $display("FAIL same_found got=0 exp=1"); end
    ar_mode = AR_RANDOM;
    wait_done(6000, ok);
    checks++; if (!ok || err !== 1'b0 || beat_count != 512 || ar_bad != 0) begin failures++; $display("FAIL same_finish got=%0b/%0b/%0d/%0d exp=1/0/512/0", ok, err, beat_count, ar_bad); end
    en = 1'b0; @(negedge clk); @(negedge clk);
  endtask

  task automatic test_no_rlast_reset();
    do_reset();
    ar_mode = AR_ALWAYS; r_mode = R_OFF;
    exp_addr = BASE; en = 1'b1;
    repeat (40) @(negedge clk);
    checks++; if (ar_count != 4 || ar_bad != 0) begin failures++; $display("FAIL nolast_accepts got=%0d/%0d exp=4/0", ar_count, ar_bad); end
    checks++; if (ARVALID !== 1'b0 || outstanding_dbg !== 4'd4) begin failures++; $display("FAIL nolast_stop got=%0b/%0d exp=0/4", ARVALID, outstanding_dbg); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (state_dbg !== ST_IDLE || busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midrst_state got=%0d/%0b/%0b exp=%0d/0/0", state_dbg, busy, done, ST_IDLE); end
    checks++; if (ARVALID !== 1'b0 || RREADY !== 1'b0) begin failures++; $display("FAIL midrst_hs got=%0b/%0b exp=0/0", ARVALID, RREADY); end
    checks++; if (ARADDR !== BASE || ARID !== 4'd0) begin failures++; $display("FAIL midrst_addr got=%h/%0d exp=%h/0", ARADDR, ARID, BASE); end
    checks++; if (outstanding_dbg !== 4'd0 || err !== 1'b0 || err_cnt !== 16'd0) begin failures++; $display("FAIL midrst_cnt got=%0d/%0b/%0d exp=0/0/0", outstanding_dbg, err, err_cnt); end
    reset = 1'b0; en = 1'b0; r_mode = R_NORMAL;
    @(negedge clk);
  endtask

  task automatic test_corrupt_stray();
    bit ok;
    do_reset();
    ar_mode = AR_RANDOM; r_mode = R_NORMAL; r_gaps = 1'b1;
    exp_addr = BASE; en = 1'b1;
    for (int i = 0; i < 500 && beat_count < 40; i++) @(negedge clk);
    corrupt_req = 1'b1;
    wait_done(6000, ok);
    checks++; if (!ok || beat_count != 512) begin failures++; $display("FAIL corrupt_done got=%0b/%0d exp=1/512", ok, beat_count); end
    checks++; if (err !== 1'b1 || err_cnt !== 16'd1) begin failures++; $display("FAIL corrupt_count got=%0b/%0d exp=1/1", err, err_cnt); end
    en = 1'b0; @(negedge clk); @(negedge clk);
    ar_mode = AR_MANUAL; ARREADY = 1'b0; en = 1'b1;
    @(negedge clk); @(negedge clk);
    stray_req = 1'b1;
    for (int i = 0; i < 10 && stray_done == 0; i++) @(negedge clk);
    checks++; if (stray_done != 1) begin failures++; $display("FAIL stray_consumed got=%0d exp=1", stray_done); end
    checks++; if (err !== 1'b1 || err_cnt !== 16'd2 || outstanding_dbg !== 4'd0) begin failures++; $display("FAIL stray_count got=%0b/%0d/%0d exp=1/2/0", err, err_cnt, outstanding_dbg); end
    do_reset();
  endtask

  task automatic test_stream_wrap();
    bit ok;
    int runs;
    do_reset();
    ar_mode = AR_ALWAYS; r_mode = R_NORMAL; r_gaps = 1'b0;
    ok = 1'b1; runs = 0;
    while (ok && stream_steps < 12 && runs < 100) begin
      do_run(3000, ok);
      runs++;
    end
    checks++; if (!ok || stream_steps != 12) begin failures++; $display("FAIL wrap_reach got=%0b/%0d exp=1/12", ok, stream_steps); end
    checks++; if (err !== 1'b0 || err_cnt !== 16'd0) begin failures++; $display("FAIL wrap_err got=%0b/%0d exp=0/0", err, err_cnt); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_run();
    test_ar_stall();
    test_same_cycle();
    test_no_rlast_reset();
    test_corrupt_stray();
    test_stream_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
